// File: rtl/bin_to_bcd.sv
// bin_to_bcd: 8-bit binary to 3-digit BCD converter using shift-add-3
// (double dabble), one bit per clock over a 20-bit working register.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   rst      - synchronous active-high reset
//   start    - request conversion of bin (sampled only in IDLE)
//   bin      - 8-bit unsigned value to convert
//   busy     - high whenever the FSM is not IDLE
//   done     - one-cycle pulse when a fresh result is on the digit outputs
//   hundreds - BCD hundreds digit (0..2)
//   tens     - BCD tens digit (0..9)
//   ones     - BCD ones digit (0..9)

module bin_to_bcd (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    // [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary
    logic [19:0] work;
    logic [19:0] work_adj;
    logic [19:0] work_shf;
    logic [2:0]  cnt;
    logic        last;

    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Correct every BCD nibble before the shift so it carries properly.
    always_comb begin
        work_adj        = work;
        work_adj[19:16] = add3(work[19:16]);
        work_adj[15:12] = add3(work[15:12]);
        work_adj[11:8]  = add3(work[11:8]);
        work_shf        = {work_adj[18:0], 1'b0};
    end

    // Counter reaches 7 on the eighth shift.
    assign last = (cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            work     <= 20'd0;
            cnt      <= 3'd0;
            hundreds <= 4'd0;
            tens     <= 4'd0;
            ones     <= 4'd0;
        end else if (state == IDLE) begin
            if (start) begin
                work <= {12'd0, bin};
                cnt  <= 3'd0;
            end
        end else if (state == SHIFT) begin
            work <= work_shf;
            cnt  <= cnt + 3'd1;
            // Digits only move on the final shift; they hold otherwise.
            if (last) begin
                hundreds <= work_shf[19:16];
                tens     <= work_shf[15:12];
                ones     <= work_shf[11:8];
            end
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_bin_to_bcd.sv
// tb_bin_to_bcd: self-checking bench for bin_to_bcd.
// Vector table, random values against an arithmetic model, corner sequences.

module tb_bin_to_bcd;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] bin;
    logic       busy;
    logic       done;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;

    int n_checks;
    int n_fail;

    bin_to_bcd dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .hundreds (hundreds),
        .tens     (tens),
        .ones     (ones)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         h;
        int         t;
        int         o;
    } vec_t;

    vec_t vecs[9];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs one conversion; returns observed digits. Checks latency,
    // pulse width, bin capture and output hold while converting.
    task automatic run_conv(input logic [7:0] b, output int h,
                            output int t, output int o);
        int n;
        int hold_ok;
        int ph;
        int pt;
        int po;
        ph = int'(hundreds);
        pt = int'(tens);
        po = int'(ones);
        hold_ok = 1;
        start = 1'b1;
        bin   = b;
        step();
        start = 1'b0;
        chk("busy_after_accept", int'(busy), 1);
        n = 0;
        while (!done && n < 20) begin
            bin = 8'($urandom);
            if (int'(hundreds) != ph || int'(tens) != pt
                || int'(ones) != po) begin
                hold_ok = 0;
            end
            step();
            n++;
        end
        chk("latency", n, 8);
        chk("hold_during_conv", hold_ok, 1);
        h = int'(hundreds);
        t = int'(tens);
        o = int'(ones);
        step();
        chk("done_one_cycle", int'(done), 0);
        chk("busy_idle_after", int'(busy), 0);
    endtask

    initial begin
        int h;
        int t;
        int o;
        int bc;
        int dc;
        int dcyc[3];
        int dval[3];
        int b;
        int rng_ok;
        int idn_ok;

        n_checks = 0;
        n_fail   = 0;

        vecs[0] = '{8'd0,   0, 0, 0};
        vecs[1] = '{8'd255, 2, 5, 5};
        vecs[2] = '{8'd99,  0, 9, 9};
        vecs[3] = '{8'd100, 1, 0, 0};
        vecs[4] = '{8'd200, 2, 0, 0};
        vecs[5] = '{8'd9,   0, 0, 9};
        vecs[6] = '{8'd10,  0, 1, 0};
        vecs[7] = '{8'd199, 1, 9, 9};
        vecs[8] = '{8'd128, 1, 2, 8};

        rst   = 1'b1;
        start = 1'b0;
        bin   = 8'd0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_digits", int'({hundreds, tens, ones}), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) begin
            run_conv(vecs[i].b, h, t, o);
            chk($sformatf("vec%0d_h", i), h, vecs[i].h);
            chk($sformatf("vec%0d_t", i), t, vecs[i].t);
            chk($sformatf("vec%0d_o", i), o, vecs[i].o);
        end

        for (int i = 0; i < 40; i++) begin
            b = int'($urandom_range(0, 255));
            run_conv(8'(b), h, t, o);
            chk($sformatf("rand%0d_b%0d", i, b),
                h * 100 + t * 10 + o, b);
            chk($sformatf("rand%0d_digits", i), h * 256 + t * 16 + o,
                (b / 100) * 256 + ((b / 10) % 10) * 16 + (b % 10));
        end

        // start again while busy must be ignored
        bc = 0;
        dc = 0;
        for (int c = 0; c < 25; c++) begin
            start = (c == 0 || c == 3);
            bin   = (c == 0) ? 8'd37 : 8'd250;
            step();
            if (busy) bc++;
            if (done) dc++;
        end
        start = 1'b0;
        chk("busy_ignore_dones", dc, 1);
        chk("busy_ignore_cycles", bc, 9);
        chk("busy_ignore_result", int'({hundreds, tens, ones}), 'h037);

        // reset in the middle of a conversion
        dc = 0;
        for (int c = 0; c < 5; c++) begin
            start = (c == 0);
            bin   = 8'd180;
            rst   = (c == 4);
            step();
            if (done) dc++;
        end
        rst   = 1'b0;
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (done) dc++;
        end
        chk("midrst_no_done", dc, 0);
        chk("midrst_digits", int'({hundreds, tens, ones}), 0);
        chk("midrst_busy", int'(busy), 0);

        // reset and start together: start ignored
        rst   = 1'b1;
        start = 1'b1;
        bin   = 8'd77;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        step();
        chk("rst_start_busy2", int'(busy), 0);
        run_conv(8'd180, h, t, o);
        chk("after_rst_180", h * 100 + t * 10 + o, 180);
        chk("after_rst_180_h", h, 1);

        // start held high: back-to-back conversions every 10 clocks
        dc = 0;
        for (int c = 0; c < 31; c++) begin
            start = (c <= 20);
            bin   = (c < 10) ? 8'd12 : (c < 20) ? 8'd34 : 8'd56;
            step();
            if (done && dc < 3) begin
                dcyc[dc] = c;
                dval[dc] = int'({hundreds, tens, ones});
                dc++;
            end
            if (c == 15) begin
                chk("cont_hold", int'({hundreds, tens, ones}), 'h012);
            end
        end
        start = 1'b0;
        chk("cont_count", dc, 3);
        if (dc == 3) begin
            chk("cont_first_at", dcyc[0], 8);
            chk("cont_space1", dcyc[1] - dcyc[0], 10);
            chk("cont_space2", dcyc[2] - dcyc[1], 10);
            chk("cont_val0", dval[0], 'h012);
            chk("cont_val1", dval[1], 'h034);
            chk("cont_val2", dval[2], 'h056);
        end
        step();
        step();

        // exhaustive sweep: identity and digit ranges
        rng_ok = 1;
        idn_ok = 1;
        for (int v = 0; v < 256; v++) begin
            run_conv(8'(v), h, t, o);
            if (h * 100 + t * 10 + o != v) idn_ok = 0;
            if (h > 2 || t > 9 || o > 9) rng_ok = 0;
        end
        chk("sweep_identity", idn_ok, 1);
        chk("sweep_range", rng_ok, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
